// File: rtl/multi_ch_readout_seq.sv
// Readout sequencer: trigger counting, back-to-back masked channel reads, ADC_LAT-aligned FIFO write enable; READOUT_TIMEOUT_EN adds a WAIT_TRIG watchdog.
// Latency: start->read clock 1 cycle, read clock->adc_read_en ADC_LAT cycles; no backpressure, sw_abort flushes everything in 1 cycle.
module multi_ch_readout_seq #(
   parameter int NUM_CH         = 4,
   parameter int SAMPLES_MAX    = 1280,
   parameter int ADC_LAT        = 3,
   parameter int TRIG_CNT_W     = 16,
   parameter int TIMEOUT_CYCLES = 4000000
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [NUM_CH-1:0]              trig_from_chip,
   input  logic [NUM_CH-1:0]              cfg_ch_mask,
   input  logic [$clog2(SAMPLES_MAX):0]   cfg_num_samples,
   input  logic                           cfg_auto_mode,
   input  logic                           sw_start,
   input  logic                           sw_abort,
   output logic [NUM_CH-1:0]              chip_read_clk_en,
   output logic                           adc_read_en,
   output logic [$clog2(NUM_CH)-1:0]      adc_ch,
   output logic [NUM_CH*TRIG_CNT_W-1:0]   trig_count,
   output logic                           busy,
   output logic                           done,
   output logic                           start_err,
   output logic                           aborted
);

   localparam int CHW = $clog2(NUM_CH);
   localparam int SW  = $clog2(SAMPLES_MAX) + 1;
   localparam logic [SW-1:0] SMAX = SW'(SAMPLES_MAX);

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, READ, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [NUM_CH-1:0]     trig_s1, trig_s2, trig_s3, trig_rise;
   logic [TRIG_CNT_W-1:0] cnt [NUM_CH];
   logic [NUM_CH-1:0]     mask_q, seen, seen_nxt;
   logic [SW-1:0]         n_q, n_clamp, smp_cnt;
   logic [CHW-1:0]        cur_ch, low_ch, nxt_ch;
   logic                  nxt_found, smp_last, all_seen;
   logic [3:0]            drain_cnt;
   logic                  start_ok, abort_go, timeout_go, done_go, start_err_go;
   logic [ADC_LAT-1:0]    pipe_en;
   logic [CHW-1:0]        pipe_ch [ADC_LAT];

   // Triggers: 2-FF synchroniser plus one stage for rising-edge detect
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trig_s1 <= '0;
         trig_s2 <= '0;
         trig_s3 <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         trig_s1 <= trig_from_chip;
         trig_s2 <= trig_s1;
         trig_s3 <= trig_s2;
         for (int i = 0; i < NUM_CH; i++)
            if (trig_rise[i]) cnt[i] <= cnt[i] + 1'b1;
      end
   end

   assign trig_rise = trig_s2 & ~trig_s3;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign trig_count[g*TRIG_CNT_W +: TRIG_CNT_W] = cnt[g];
   end

   assign n_clamp  = (cfg_num_samples == '0 || cfg_num_samples > SMAX) ? SMAX : cfg_num_samples;
   assign start_ok = sw_start && (cfg_ch_mask != '0);
   assign seen_nxt = seen | (trig_rise & mask_q);
   assign all_seen = (seen_nxt == mask_q);
   assign smp_last = (smp_cnt == n_q - 1'b1);

   always_comb begin
      low_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (cfg_ch_mask[i]) low_ch = CHW'(i);
   end

   always_comb begin
      nxt_found = 1'b0;
      nxt_ch    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask_q[i] && i > int'(cur_ch)) begin
            nxt_found = 1'b1;
            nxt_ch    = CHW'(i);
         end
   end

`ifdef READOUT_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOW-1:0] to_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  to_cnt <= '0;
      else if (state != WAIT_TRIG) to_cnt <= '0;
      else                        to_cnt <= to_cnt + 1'b1;
   end

   assign timeout_go = (state == WAIT_TRIG) && !all_seen && !sw_abort &&
                       (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_go = 1'b0;
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
`endif

   assign abort_go     = sw_abort && (state != IDLE);
   assign done_go      = (state == DRAIN) && (drain_cnt == 4'(ADC_LAT - 1)) && !abort_go;
   assign start_err_go = sw_start && ((state == IDLE) ? (cfg_ch_mask == '0) : !abort_go);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_ok) state_nxt = cfg_auto_mode ? WAIT_TRIG : READ;
         WAIT_TRIG: if (all_seen) state_nxt = READ;
                    else if (timeout_go) state_nxt = IDLE;
         READ:      if (smp_last && !nxt_found) state_nxt = DRAIN;
         DRAIN:     if (drain_cnt == 4'(ADC_LAT - 1)) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (abort_go) state_nxt = IDLE;
   end

   always_comb begin
      chip_read_clk_en = '0;
      if (state == READ) chip_read_clk_en[cur_ch] = 1'b1;
      busy = (state != IDLE);
   end

   // cur_ch is loaded with the lowest mask bit at start, so WAIT_TRIG->READ needs no reload
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mask_q    <= '0;
         n_q       <= '0;
         cur_ch    <= '0;
         smp_cnt   <= '0;
         seen      <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               mask_q  <= cfg_ch_mask;
               n_q     <= n_clamp;
               cur_ch  <= low_ch;
               smp_cnt <= '0;
               seen    <= '0;
            end
            WAIT_TRIG: seen <= seen_nxt;
            READ: begin
               if (smp_last) begin
                  smp_cnt   <= '0;
                  drain_cnt <= '0;
                  if (nxt_found) cur_ch <= nxt_ch;
               end else begin
                  smp_cnt <= smp_cnt + 1'b1;
               end
            end
            DRAIN: drain_cnt <= drain_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done      <= 1'b0;
         aborted   <= 1'b0;
         start_err <= 1'b0;
      end else begin
         done      <= done_go;
         aborted   <= abort_go | timeout_go;
         start_err <= start_err_go;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_en <= '0;
         for (int i = 0; i < ADC_LAT; i++) pipe_ch[i] <= '0;
      end else if (abort_go) begin
         pipe_en <= '0;
         for (int i = 0; i < ADC_LAT; i++) pipe_ch[i] <= '0;
      end else begin
         pipe_en[0] <= |chip_read_clk_en;
         pipe_ch[0] <= cur_ch;
         for (int i = 1; i < ADC_LAT; i++) begin
            pipe_en[i] <= pipe_en[i-1];
            pipe_ch[i] <= pipe_ch[i-1];
         end
      end
   end

   assign adc_read_en = pipe_en[ADC_LAT-1];
   assign adc_ch      = pipe_ch[ADC_LAT-1];

endmodule
